// File: rtl/module_bcd_scheduler_pkg.sv
// rtl/module_bcd_scheduler_pkg.sv - shared state encoding and constants for the BCD scheduler
package module_bcd_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Blank/error code written into every digit of an aborted result
  localparam logic [3:0] BCD_ERR_DIGIT = 4'hF;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/module_bcd_scheduler_arbiter.sv
// rtl/module_bcd_scheduler_arbiter.sv - two-input round-robin grant (module_rr_arbiter2)
module module_rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);
  import module_bcd_scheduler_pkg::*;

  // On contention the requester that was not served last time wins
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else if (req1) begin
      grant_id = REQ1;
    end else begin
      grant_id = REQ0;
    end
  end

endmodule

// File: rtl/module_bcd_scheduler.sv
// rtl/module_bcd_scheduler.sv - shares one multi-cycle binary-to-BCD converter between two requesters
module module_bcd_scheduler #(
  parameter int WIDTH   = 8,
  parameter int DIGITS  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_i,
  input  logic [WIDTH-1:0]      bin0_i,
  output logic                  ack0_o,
  output logic [4*DIGITS-1:0]   bcd0_o,
  input  logic                  req1_i,
  input  logic [WIDTH-1:0]      bin1_i,
  output logic                  ack1_o,
  output logic [4*DIGITS-1:0]   bcd1_o,
  output logic                  conv_start_o,
  output logic [WIDTH-1:0]      conv_bin_o,
  input  logic                  conv_done_i,
  input  logic [4*DIGITS-1:0]   conv_bcd_i,
  output logic                  busy_o,
  output logic                  timeout_o
);
  import module_bcd_scheduler_pkg::*;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_next;
  logic          last_grant;
  logic          grant_id_q;
  logic [CW-1:0] cnt;
  logic          grant_valid;
  logic          grant_id;
  logic          wait_done;
  logic          wait_abort;

  module_rr_arbiter2 u_arb (
    .req0        (req0_i),
    .req1        (req1_i),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // A done strobe in the final counted cycle still delivers real data
  assign wait_done  = (state == WAIT) && conv_done_i;
  assign wait_abort = (state == WAIT) && !conv_done_i && (cnt == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (wait_done || wait_abort) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conv_bin_o <= '0;
      grant_id_q <= REQ0;
      last_grant <= REQ1;
      cnt        <= '0;
      bcd0_o     <= '0;
      bcd1_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            grant_id_q <= grant_id;
            conv_bin_o <= (grant_id == REQ1) ? bin1_i : bin0_i;
          end
        end
        LAUNCH: cnt <= '0;
        WAIT: begin
          if (wait_done) begin
            if (grant_id_q == REQ1) bcd1_o <= conv_bcd_i;
            else                    bcd0_o <= conv_bcd_i;
          end else if (wait_abort) begin
            if (grant_id_q == REQ1) bcd1_o <= {DIGITS{BCD_ERR_DIGIT}};
            else                    bcd0_o <= {DIGITS{BCD_ERR_DIGIT}};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: last_grant <= grant_id_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    conv_start_o = (state == LAUNCH);
    busy_o       = (state != IDLE);
    ack0_o       = (state == RESP) && (grant_id_q == REQ0);
    ack1_o       = (state == RESP) && (grant_id_q == REQ1);
    timeout_o    = wait_abort;
  end

endmodule

// File: tb/tb_module_bcd_scheduler.sv
// tb/tb_module_bcd_scheduler.sv - self-checking bench for module_bcd_scheduler
module tb_module_bcd_scheduler;
  localparam int WIDTH = 8;
  localparam int DIGITS = 3;
  localparam int TIMEOUT = 64;
  localparam int BW = 4 * DIGITS;

  logic clk = 0;
  logic rst;
  logic req0, req1;
  logic [WIDTH-1:0] bin0, bin1;
  logic ack0, ack1;
  logic [BW-1:0] bcd0, bcd1;
  logic conv_start;
  logic [WIDTH-1:0] conv_bin;
  logic conv_done;
  logic [BW-1:0] conv_bcd;
  logic busy, timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int conv_delay = 1;
  bit conv_hang = 0;
  bit force_done = 0;
  logic [BW-1:0] force_bcd = '0;
  int start_count = 0;
  int start_cyc = -1;

  logic [BW-1:0] exp_bcd0, exp_bcd1;
  int model_last;

  module_bcd_scheduler #(.WIDTH(WIDTH), .DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .bin0_i(bin0), .ack0_o(ack0), .bcd0_o(bcd0),
    .req1_i(req1), .bin1_i(bin1), .ack1_o(ack1), .bcd1_o(bcd1),
    .conv_start_o(conv_start), .conv_bin_o(conv_bin),
    .conv_done_i(conv_done), .conv_bcd_i(conv_bcd),
    .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] bcd_of(input int v);
    logic [BW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Converter model: done strobe k cycles after start, garbage on the bus otherwise
  initial begin : conv_model
    int cnt;
    logic [WIDTH-1:0] held;
    cnt = 0; held = '0; conv_done = 0; conv_bcd = '0;
    forever begin
      @(negedge clk); #1;
      conv_done = force_done;
      conv_bcd = force_done ? force_bcd : BW'($urandom);
      if (rst) begin
        cnt = 0;
      end else if (conv_start) begin
        held = conv_bin; start_count++; start_cyc = cyc;
        cnt = conv_hang ? 0 : conv_delay;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin conv_done = 1; conv_bcd = bcd_of(int'(held)); end
      end
    end
  end

  task automatic wait_ack(output bit got, output int id, output int at, output int tcyc);
    got = 0; id = -1; at = -1; tcyc = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk); #2;
      if (timeout) tcyc = cyc;
      if (ack0 || ack1) begin got = 1; id = ack1 ? 1 : 0; at = cyc; end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1; req0 = 0; req1 = 0;
    @(negedge clk); @(negedge clk); rst = 0;
    exp_bcd0 = '0; exp_bcd1 = '0; model_last = 1;
  endtask

  task automatic test_reset();
    @(negedge clk); #2;
    checks++;
    if ({busy, ack0, ack1, conv_start, timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, ack0, ack1, conv_start, timeout});
    end
    checks++;
    if ({bcd0, bcd1, conv_bin} !== '0) begin
      errors++; $display("FAIL reset_data: bcd0=%h bcd1=%h bin=%h expected all 0", bcd0, bcd1, conv_bin);
    end
    @(negedge clk); rst = 0;
    exp_bcd0 = '0; exp_bcd1 = '0; model_last = 1;
  endtask

  task automatic test_single();
    bit got; int id, at, tc, n, s0;
    @(negedge clk);
    conv_delay = 5; s0 = start_count; n = cyc;
    req0 = 1; bin0 = 8'd173;
    wait_ack(got, id, at, tc);
    req0 = 0;
    checks++;
    if (got !== 1'b1 || id !== 0) begin errors++; $display("FAIL single_ack: got=%0d id=%0d expected ack0", got, id); end
    checks++;
    if (at !== n + 7) begin errors++; $display("FAIL single_latency: ack at %0d expected %0d", at, n + 7); end
    checks++;
    if (bcd0 !== 12'h173 || bcd1 !== 12'h000) begin
      errors++; $display("FAIL single_bcd: bcd0=%h bcd1=%h expected 173/000", bcd0, bcd1);
    end
    checks++;
    if (conv_bin !== 8'd173 || start_count - s0 !== 1) begin
      errors++; $display("FAIL single_start: bin=%0d starts=%0d expected 173/1", conv_bin, start_count - s0);
    end
    exp_bcd0 = 12'h173; model_last = 0;
  endtask

  task automatic test_both();
    bit got; int id, at, tc, s0;
    apply_reset();
    @(negedge clk);
    conv_delay = 3; s0 = start_count;
    req0 = 1; bin0 = 8'd42; req1 = 1; bin1 = 8'd255;
    wait_ack(got, id, at, tc);
    req0 = 0;
    checks++;
    if (id !== 0 || bcd0 !== 12'h042 || bcd1 !== 12'h000) begin
      errors++; $display("FAIL both_first: id=%0d bcd0=%h bcd1=%h expected 0/042/000", id, bcd0, bcd1);
    end
    wait_ack(got, id, at, tc);
    req1 = 0;
    checks++;
    if (id !== 1 || bcd1 !== 12'h255 || bcd0 !== 12'h042) begin
      errors++; $display("FAIL both_second: id=%0d bcd1=%h bcd0=%h expected 1/255/042", id, bcd1, bcd0);
    end
    checks++;
    if (start_count - s0 !== 2) begin errors++; $display("FAIL both_starts: got %0d expected 2", start_count - s0); end
    exp_bcd0 = 12'h042; exp_bcd1 = 12'h255; model_last = 1;
  endtask

  task automatic test_fairness();
    bit got; int id, at, tc, k, exp_id;
    @(negedge clk);
    k = $urandom_range(1, 8); conv_delay = k;
    bin0 = WIDTH'($urandom); bin1 = WIDTH'($urandom);
    req0 = 1; req1 = 1;
    for (int i = 0; i < 6; i++) begin
      exp_id = (model_last == 0) ? 1 : 0;
      if (exp_id == 0) exp_bcd0 = bcd_of(int'(bin0)); else exp_bcd1 = bcd_of(int'(bin1));
      wait_ack(got, id, at, tc);
      checks++;
      if (id !== exp_id) begin errors++; $display("FAIL fair_grant[%0d]: got %0d expected %0d", i, id, exp_id); end
      checks++;
      if ({bcd1, bcd0} !== {exp_bcd1, exp_bcd0}) begin
        errors++; $display("FAIL fair_bcd[%0d]: got %h/%h expected %h/%h", i, bcd1, bcd0, exp_bcd1, exp_bcd0);
      end
      checks++;
      if (at !== start_cyc + k + 1) begin errors++; $display("FAIL fair_latency[%0d]: got %0d expected %0d", i, at, start_cyc + k + 1); end
      model_last = exp_id;
      if (exp_id == 0) bin0 = WIDTH'($urandom); else bin1 = WIDTH'($urandom);
      k = $urandom_range(1, 8); conv_delay = k;
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_random();
    bit got; int id, at, tc, k, n, who;
    logic [WIDTH-1:0] b;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      who = $urandom_range(0, 1); b = WIDTH'($urandom); k = $urandom_range(1, 10);
      conv_delay = k; n = cyc;
      if (who == 0) begin req0 = 1; bin0 = b; exp_bcd0 = bcd_of(int'(b)); end
      else begin req1 = 1; bin1 = b; exp_bcd1 = bcd_of(int'(b)); end
      wait_ack(got, id, at, tc);
      req0 = 0; req1 = 0;
      checks++;
      if (id !== who || at !== n + 2 + k) begin
        errors++; $display("FAIL rand_ack[%0d]: id=%0d at=%0d expected %0d at %0d", i, id, at, who, n + 2 + k);
      end
      checks++;
      if ({bcd1, bcd0} !== {exp_bcd1, exp_bcd0}) begin
        errors++; $display("FAIL rand_bcd[%0d]: got %h/%h expected %h/%h", i, bcd1, bcd0, exp_bcd1, exp_bcd0);
      end
      model_last = who;
    end
  endtask

  task automatic test_timeout();
    bit got; int id, at, tc;
    logic [WIDTH-1:0] b;
    @(negedge clk);
    conv_hang = 1; req1 = 1; bin1 = 8'd9;
    wait_ack(got, id, at, tc);
    req1 = 0; conv_hang = 0;
    checks++;
    if (tc !== start_cyc + TIMEOUT) begin errors++; $display("FAIL timeout_pulse: at %0d expected %0d", tc, start_cyc + TIMEOUT); end
    checks++;
    if (id !== 1 || at !== start_cyc + TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_ack: id=%0d at=%0d expected 1 at %0d", id, at, start_cyc + TIMEOUT + 1);
    end
    exp_bcd1 = '1;
    checks++;
    if ({bcd1, bcd0} !== {exp_bcd1, exp_bcd0}) begin
      errors++; $display("FAIL timeout_bcd: got %h/%h expected %h/%h", bcd1, bcd0, exp_bcd1, exp_bcd0);
    end
    model_last = 1;
    // done lands in the very last counted cycle: data must win
    @(negedge clk);
    b = WIDTH'($urandom); conv_delay = TIMEOUT; req0 = 1; bin0 = b;
    wait_ack(got, id, at, tc);
    req0 = 0;
    exp_bcd0 = bcd_of(int'(b));
    checks++;
    if (tc !== -1 || id !== 0 || at !== start_cyc + TIMEOUT + 1) begin
      errors++; $display("FAIL coincide_ack: tcyc=%0d id=%0d at=%0d expected -1/0/%0d", tc, id, at, start_cyc + TIMEOUT + 1);
    end
    checks++;
    if (bcd0 !== exp_bcd0) begin errors++; $display("FAIL coincide_bcd: got %h expected %h", bcd0, exp_bcd0); end
    model_last = 0;
  endtask

  task automatic test_spurious();
    bit got, seen; int id, at, tc;
    @(negedge clk);
    force_bcd = 12'h999; force_done = 1;
    @(negedge clk);
    force_done = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      if (ack0 || ack1 || busy) seen = 1;
    end
    checks++;
    if (seen !== 1'b0 || {bcd1, bcd0} !== {exp_bcd1, exp_bcd0}) begin
      errors++; $display("FAIL spurious_done: activity=%0d bcd=%h/%h expected 0 %h/%h", seen, bcd1, bcd0, exp_bcd1, exp_bcd0);
    end
    conv_delay = 6; req0 = 1; bin0 = 8'd5;
    for (int i = 0; i < 3; i++) @(negedge clk);
    bin0 = 8'd7;
    wait_ack(got, id, at, tc);
    req0 = 0;
    exp_bcd0 = 12'h005;
    checks++;
    if (id !== 0 || bcd0 !== 12'h005 || conv_bin !== 8'd5) begin
      errors++; $display("FAIL operand_hold: id=%0d bcd0=%h bin=%0d expected 0/005/5", id, bcd0, conv_bin);
    end
    model_last = 0;
  endtask

  task automatic test_reset_mid();
    bit seen; int s0;
    @(negedge clk);
    conv_delay = 30; req0 = 1; bin0 = WIDTH'($urandom_range(1, 255));
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #2;
      if (conv_start) seen = 1;
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_start: got no start expected one"); end
    @(negedge clk); @(negedge clk);
    rst = 1; #1;
    checks++;
    if ({busy, ack0, ack1, conv_start, timeout} !== 5'b0 || {bcd0, bcd1, conv_bin} !== '0) begin
      errors++; $display("FAIL rstmid_clear: ctrl=%b bcd0=%h bcd1=%h bin=%h expected all 0",
                         {busy, ack0, ack1, conv_start, timeout}, bcd0, bcd1, conv_bin);
    end
    req0 = 0;
    @(negedge clk); rst = 0;
    exp_bcd0 = '0; exp_bcd1 = '0; model_last = 1;
    s0 = start_count;
    @(negedge clk); force_bcd = 12'h123; force_done = 1;
    @(negedge clk); force_done = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      if (ack0 || ack1 || busy || conv_start) seen = 1;
    end
    checks++;
    if (seen !== 1'b0 || start_count !== s0 || {bcd1, bcd0} !== '0) begin
      errors++; $display("FAIL rstmid_after: activity=%0d starts=%0d bcd=%h/%h expected 0/%0d/000/000",
                         seen, start_count - s0, bcd1, bcd0, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 0; req0 = 0; req1 = 0; bin0 = '0; bin1 = '0;
    exp_bcd0 = '0; exp_bcd1 = '0; model_last = 1;
    #2 rst = 1;
    test_reset();
    test_single();
    test_both();
    test_fairness();
    test_random();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
